fetch_control: RTL

- Sequencer for the fetch-issue PC register; generates its 2-bit next-PC select and target PC every cycle.
- Arbitrates between boot vector, execute-stage redirects, hazard stalls and instruction-cache miss back-pressure.
- Tells fetch-receive which issued PCs are valid, and when to flush.
- Sits between hazard/branch logic and the fetch-issue PC register, one instance per core.

---
 rtl/fetch_control_if.sv | 24 ++
 rtl/fetch_control.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_control_if.sv
// Fetch-control handshake bundle: branch/hazard/icache inputs and next-PC controls.
// master = hazard/branch side, slave = fetch_control.
interface fetch_control_if #(
    parameter int unsigned ADDRESS_BITS = 20
);
    logic                    redirect_valid;
    logic [ADDRESS_BITS-1:0] redirect_PC;
    logic                    stall;
    logic                    icache_ready;
    logic [1:0]              next_PC_select;
    logic [ADDRESS_BITS-1:0] target_PC;
    logic                    fetch_valid;
    logic                    flush;

    modport master (
        output redirect_valid, redirect_PC, stall, icache_ready,
        input  next_PC_select, target_PC, fetch_valid, flush
    );

    modport slave (
        input  redirect_valid, redirect_PC, stall, icache_ready,
        output next_PC_select, target_PC, fetch_valid, flush
    );
endinterface

// File: rtl/fetch_control.sv
// Next-PC sequencer for the fetch-issue PC register: boot, redirects, stalls, icache misses.
// Optional macro FETCH_CONTROL_PERF_EN adds saturating redirect/miss performance counters.
module fetch_control #(
    parameter int unsigned              CORE            = 0,
    parameter int unsigned              ADDRESS_BITS    = 20,
    parameter logic [ADDRESS_BITS-1:0]  RESET_PC        = '0,
    parameter int unsigned              FLUSH_CYCLES    = 2,
    parameter int unsigned              SCAN_CYCLES_MIN = 1,
    parameter int unsigned              SCAN_CYCLES_MAX = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              scan,
    fetch_control_if.slave    bus
);
    typedef enum logic [1:0] {StBoot, StRun, StMissWait, StFlush} state_e;

    localparam logic [1:0] SelInc  = 2'b00;
    localparam logic [1:0] SelHold = 2'b01;
    localparam logic [1:0] SelLoad = 2'b10;
    localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

    state_e                  state_q, state_d;
    logic                    pending_valid_q, pending_valid_d;
    logic [ADDRESS_BITS-1:0] pending_pc_q, pending_pc_d;
    logic [3:0]              flush_cnt_q, flush_cnt_d;
    logic [ADDRESS_BITS-1:0] last_target_q;
    logic [31:0]             cycle_q;

    logic [1:0]              sel;
    logic [ADDRESS_BITS-1:0] tgt;
    logic                    fetch_valid;
    logic                    flush;

    always_comb begin
        state_d         = state_q;
        pending_valid_d = pending_valid_q;
        pending_pc_d    = pending_pc_q;
        flush_cnt_d     = flush_cnt_q;
        sel             = SelHold;
        tgt             = last_target_q;
        fetch_valid     = 1'b0;
        flush           = 1'b0;

        unique case (state_q)
            StBoot: begin
                sel         = SelLoad;
                tgt         = RESET_PC;
                flush       = 1'b1;
                state_d     = StFlush;
                flush_cnt_d = FlushInit;
            end
            StRun: begin
                if (!bus.icache_ready) begin
                    state_d = StMissWait;
                    if (bus.redirect_valid) begin
                        pending_valid_d = 1'b1;
                        pending_pc_d    = bus.redirect_PC;
                    end
                end else if (bus.redirect_valid) begin
                    sel         = SelLoad;
                    tgt         = bus.redirect_PC;
                    flush       = 1'b1;
                    state_d     = StFlush;
                    flush_cnt_d = FlushInit;
                end else if (!bus.stall) begin
                    sel         = SelInc;
                    fetch_valid = 1'b1;
                end
            end
            StMissWait: begin
                flush = pending_valid_q;
                if (bus.icache_ready && (pending_valid_q || bus.redirect_valid)) begin
                    // A redirect arriving with the refill beats the captured one.
                    sel             = SelLoad;
                    tgt             = bus.redirect_valid ? bus.redirect_PC : pending_pc_q;
                    pending_valid_d = 1'b0;
                    state_d         = StFlush;
                    flush_cnt_d     = FlushInit;
                end else if (bus.icache_ready) begin
                    state_d = StRun;
                end else if (bus.redirect_valid) begin
                    pending_valid_d = 1'b1;
                    pending_pc_d    = bus.redirect_PC;
                end
            end
            StFlush: begin
                flush = 1'b1;
                sel   = (bus.icache_ready && !bus.stall) ? SelInc : SelHold;
                if (bus.redirect_valid) begin
                    sel         = SelLoad;
                    tgt         = bus.redirect_PC;
                    flush_cnt_d = FlushInit;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    if (flush_cnt_q == 4'd1) state_d = StRun;
                end
            end
        endcase

        // Reset overrides the outputs combinationally so they change without waiting on a clock.
        if (reset) begin
            sel         = SelHold;
            tgt         = RESET_PC;
            fetch_valid = 1'b0;
            flush       = 1'b1;
        end
    end

    assign bus.next_PC_select = sel;
    assign bus.target_PC      = tgt;
    assign bus.fetch_valid    = fetch_valid;
    assign bus.flush          = flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StBoot;
            pending_valid_q <= 1'b0;
            pending_pc_q    <= '0;
            flush_cnt_q     <= 4'd0;
            last_target_q   <= RESET_PC;
            cycle_q         <= 32'd0;
        end else begin
            state_q         <= state_d;
            pending_valid_q <= pending_valid_d;
            pending_pc_q    <= pending_pc_d;
            flush_cnt_q     <= flush_cnt_d;
            cycle_q         <= cycle_q + 32'd1;
            if (sel == SelLoad) last_target_q <= tgt;
        end
    end

`ifdef FETCH_CONTROL_PERF_EN
    logic [31:0] redirect_count_q;
    logic [31:0] miss_cycles_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirect_count_q <= 32'd0;
            miss_cycles_q    <= 32'd0;
        end else begin
            if (bus.redirect_valid && state_q != StBoot && redirect_count_q != '1) begin
                redirect_count_q <= redirect_count_q + 32'd1;
            end
            if ((state_q == StMissWait || (state_q == StRun && !bus.icache_ready))
                && miss_cycles_q != '1) begin
                miss_cycles_q <= miss_cycles_q + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (scan && cycle_q >= SCAN_CYCLES_MIN && cycle_q <= SCAN_CYCLES_MAX) begin
`ifdef FETCH_CONTROL_PERF_EN
            $display("[fetch_control %0d] cyc=%0d st=%s sel=%b tgt=%h flush=%b fv=%b pend=%b/%h redir=%0d miss=%0d",
                     CORE, cycle_q, state_q.name(), sel, tgt, flush, fetch_valid,
                     pending_valid_q, pending_pc_q, redirect_count_q, miss_cycles_q);
`else
            $display("[fetch_control %0d] cyc=%0d st=%s sel=%b tgt=%h flush=%b fv=%b pend=%b/%h",
                     CORE, cycle_q, state_q.name(), sel, tgt, flush, fetch_valid,
                     pending_valid_q, pending_pc_q);
`endif
        end
    end
`endif
endmodule
